// File: rtl/bus_pkg.sv
// Shared types and constants for the single-master, four-slave request demultiplexer.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int SEL_W       = 2;
  localparam int TIMEOUT_DEF = 15;
  localparam int ERR_RDATA   = 0;

endpackage

// File: rtl/mux4.sv
// Four-input data selector; purely combinational, no flow control.
module mux4 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    case (s)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/bus_demux4.sv
// One-outstanding request demux to four slaves; response 2 cycles after request with a zero-wait slave.
// The master is held off by ignoring m_req outside IDLE; a stalled slave is abandoned after TIMEOUT cycles.
module bus_demux4
  import bus_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 32,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_req,
  input  logic              m_we,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [WIDTH-1:0]  m_wdata,
  output logic              m_ack,
  output logic              m_err,
  output logic [WIDTH-1:0]  m_rdata,
  output logic [3:0]        s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [WIDTH-1:0]  s_wdata,
  input  logic [3:0]        s_ack,
  input  logic [WIDTH-1:0]  s_rdata0,
  input  logic [WIDTH-1:0]  s_rdata1,
  input  logic [WIDTH-1:0]  s_rdata2,
  input  logic [WIDTH-1:0]  s_rdata3
);

  // Counter value seen during the last BUSY cycle before the timeout fires.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   sel_rdata;

  mux4 #(.WIDTH(WIDTH)) u_rdata_mux (
    .s  (sel_q),
    .d0 (s_rdata0),
    .d1 (s_rdata1),
    .d2 (s_rdata2),
    .d3 (s_rdata3),
    .y  (sel_rdata)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          sel_d   = m_addr[SEL_LSB +: SEL_W];
          we_d    = m_we;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          cnt_d   = 8'd0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // The ack is checked first so it wins on the final allowed cycle.
        if (s_ack[sel_q]) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = WIDTH'(ERR_RDATA);
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign m_ack   = (state_q == ST_RESP);
  assign m_err   = err_q;
  assign m_rdata = rdata_q;
  assign s_req   = (state_q == ST_BUSY) ? (4'b0001 << sel_q) : 4'b0000;
  assign s_we    = we_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;

endmodule

// File: tb/tb_bus_demux4.sv
// Scenario bench for bus_demux4: expected responses are queued at request time and compared at m_ack.
module tb_bus_demux4;

  logic        clk;
  logic        reset;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic        m_err;
  logic [31:0] m_rdata;
  logic [3:0]  s_req;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_ack;
  logic [31:0] s_rdata0, s_rdata1, s_rdata2, s_rdata3;

  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  bus_demux4 #(.WIDTH(32), .ADDR_W(32), .SEL_LSB(12), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata), .s_req(s_req), .s_we(s_we),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_ack(s_ack), .s_rdata0(s_rdata0),
    .s_rdata1(s_rdata1), .s_rdata2(s_rdata2), .s_rdata3(s_rdata3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Drive a request for the next rising edge and queue its expected {err, rdata}.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [32:0] exp);
    m_req   = 1'b1;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wd;
    exp_q.push_back(exp);
  endtask

  // Walk the transaction at falling edges, acking with pre_ack for n_pre BUSY cycles then post_ack.
  task automatic run_busy(input int n_pre, input logic [3:0] pre_ack, input logic [3:0] post_ack,
                          output int cycles, output int busy, output logic [3:0] seen,
                          output logic stable, output logic got);
    logic [31:0] a0, w0;
    logic        we0;
    cycles = 0; busy = 0; seen = 4'b0000; stable = 1'b1; got = 1'b0;
    a0 = '0; w0 = '0; we0 = 1'b0;
    while (!got && cycles < 40) begin
      @(negedge clk);
      cycles++;
      m_req = 1'b0;
      if (m_ack === 1'b1) begin
        got   = 1'b1;
        s_ack = 4'b0000;
      end else if (s_req !== 4'b0000) begin
        busy++;
        seen |= s_req;
        if (busy == 1) begin
          a0 = s_addr; w0 = s_wdata; we0 = s_we;
        end else if (s_addr !== a0 || s_wdata !== w0 || s_we !== we0) begin
          stable = 1'b0;
        end
        s_ack = (busy <= n_pre) ? pre_ack : post_ack;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; s_ack = 4'b0000;
    s_rdata0 = 32'h0; s_rdata1 = 32'h0; s_rdata2 = 32'h0; s_rdata3 = 32'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s_req, m_ack, m_err, s_we} !== 7'b0) begin
      n_fail++; $display("FAIL rst_ctl: s_req/ack/err/we=%b want 0", {s_req, m_ack, m_err, s_we});
    end
    n_checks++;
    if (s_addr !== 32'h0 || s_wdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_sbus: s_addr=%h s_wdata=%h want 0", s_addr, s_wdata);
    end
    n_checks++;
    if (m_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_rdata: m_rdata=%h want 0", m_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_req !== 4'b0000 || m_ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: s_req=%b m_ack=%b want 0/0", s_req, m_ack);
    end
  endtask

  task automatic check_response(input string name, input logic got);
    logic [32:0] exp;
    n_checks++;
    if (got !== 1'b1) begin
      n_fail++; $display("FAIL %s_ack: no m_ack within budget", name);
    end
    exp = 33'h0;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    n_checks++;
    if ({m_err, m_rdata} !== exp) begin
      n_fail++; $display("FAIL %s_resp: err/rdata=%b/%h want %b/%h", name, m_err, m_rdata, exp[32], exp[31:0]);
    end
  endtask

  task automatic test_zero_wait_read();
    int cyc, busy; logic [3:0] seen; logic stable, got;
    s_rdata2 = 32'hCAFE_0002;
    @(negedge clk);
    issue(1'b0, 32'h0000_2004, 32'h0, {1'b0, 32'hCAFE_0002});
    run_busy(0, 4'b0000, 4'b0100, cyc, busy, seen, stable, got);
    check_response("zw", got);
    n_checks++;
    if (cyc !== 2 || busy !== 1 || seen !== 4'b0100) begin
      n_fail++; $display("FAIL zw_timing: cyc=%0d busy=%0d s_req=%b want 2/1/0100", cyc, busy, seen);
    end
    @(negedge clk);
    n_checks++;
    if (m_ack !== 1'b0 || m_rdata !== 32'hCAFE_0002 || m_err !== 1'b0) begin
      n_fail++; $display("FAIL zw_hold: ack=%b rdata=%h err=%b want 0/cafe0002/0", m_ack, m_rdata, m_err);
    end
  endtask

  task automatic test_write_wait();
    int cyc, busy; logic [3:0] seen; logic stable, got;
    s_rdata1 = 32'h1111_0001;
    @(negedge clk);
    issue(1'b1, 32'h0000_1000, 32'h1234_5678, {1'b0, 32'h1111_0001});
    run_busy(3, 4'b0000, 4'b0010, cyc, busy, seen, stable, got);
    check_response("wr", got);
    n_checks++;
    if (cyc !== 5 || busy !== 4 || seen !== 4'b0010) begin
      n_fail++; $display("FAIL wr_timing: cyc=%0d busy=%0d s_req=%b want 5/4/0010", cyc, busy, seen);
    end
    n_checks++;
    if (stable !== 1'b1 || s_wdata !== 32'h1234_5678 || s_we !== 1'b1 || s_addr !== 32'h0000_1000) begin
      n_fail++; $display("FAIL wr_sbus: stable=%b wdata=%h we=%b addr=%h want 1/12345678/1/00001000",
                         stable, s_wdata, s_we, s_addr);
    end
    @(negedge clk);
    n_checks++;
    if (m_ack !== 1'b0) begin
      n_fail++; $display("FAIL wr_single: m_ack=%b one cycle after pulse, want 0", m_ack);
    end
  endtask

  task automatic test_timeout();
    int cyc, busy; logic [3:0] seen; logic stable, got;
    s_rdata3 = 32'hDEAD_0003;
    @(negedge clk);
    issue(1'b0, 32'h0000_3000, 32'h0, {1'b1, 32'h0});
    run_busy(100, 4'b0000, 4'b0000, cyc, busy, seen, stable, got);
    check_response("to", got);
    n_checks++;
    if (cyc !== 16 || busy !== 15 || seen !== 4'b1000) begin
      n_fail++; $display("FAIL to_timing: cyc=%0d busy=%0d s_req=%b want 16/15/1000", cyc, busy, seen);
    end
    @(negedge clk);
    n_checks++;
    if (m_ack !== 1'b0 || m_err !== 1'b1 || m_rdata !== 32'h0) begin
      n_fail++; $display("FAIL to_hold: ack=%b err=%b rdata=%h want 0/1/0", m_ack, m_err, m_rdata);
    end
  endtask

  task automatic test_ack_at_timeout();
    int cyc, busy; logic [3:0] seen; logic stable, got;
    s_rdata0 = 32'h0BAD_F00D;
    @(negedge clk);
    issue(1'b0, 32'h0000_0040, 32'h0, {1'b0, 32'h0BAD_F00D});
    run_busy(14, 4'b0000, 4'b0001, cyc, busy, seen, stable, got);
    check_response("edge", got);
    n_checks++;
    if (busy !== 15 || seen !== 4'b0001) begin
      n_fail++; $display("FAIL edge_timing: busy=%0d s_req=%b want 15/0001", busy, seen);
    end
  endtask

  task automatic test_spurious_ack();
    int cyc, busy; logic [3:0] seen; logic stable, got;
    s_rdata0 = 32'h0000_0BAD;
    s_rdata2 = 32'hCAFE_2222;
    @(negedge clk);
    issue(1'b0, 32'h0000_2000, 32'h0, {1'b0, 32'hCAFE_2222});
    run_busy(5, 4'b0001, 4'b0100, cyc, busy, seen, stable, got);
    check_response("spur", got);
    n_checks++;
    if (cyc !== 7 || busy !== 6 || seen !== 4'b0100) begin
      n_fail++; $display("FAIL spur_timing: cyc=%0d busy=%0d s_req=%b want 7/6/0100", cyc, busy, seen);
    end
  endtask

  task automatic test_reset_mid_busy();
    int cyc, busy, acks; logic [3:0] seen; logic stable, got;
    s_ack = 4'b0000;
    s_rdata1 = 32'h5151_0001;
    @(negedge clk);
    issue(1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 33'h0);
    @(negedge clk);
    m_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_back());
    n_checks++;
    if ({s_req, m_ack, m_err, s_we} !== 7'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0 || m_rdata !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst: s_req=%b ack=%b err=%b we=%b addr=%h wdata=%h rdata=%h want all 0",
                         s_req, m_ack, m_err, s_we, s_addr, s_wdata, m_rdata);
    end
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_ack === 1'b1) acks++;
    end
    n_checks++;
    if (acks !== 0) begin
      n_fail++; $display("FAIL mid_noack: saw %0d m_ack pulses after abort, want 0", acks);
    end
    issue(1'b0, 32'h0000_1008, 32'h0, {1'b0, 32'h5151_0001});
    run_busy(0, 4'b0000, 4'b0010, cyc, busy, seen, stable, got);
    check_response("mid_next", got);
  endtask

  task automatic test_back_to_back();
    int nack, t1, t2;
    logic [32:0] exp;
    s_rdata0 = 32'hB2B0_0000;
    s_rdata3 = 32'hB2B0_0003;
    s_ack    = 4'b1001;
    nack = 0; t1 = 0; t2 = 0;
    @(negedge clk);
    issue(1'b0, 32'h0000_0000, 32'h0, {1'b0, 32'hB2B0_0000});
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) begin
        m_addr = 32'h0000_3000;
        exp_q.push_back({1'b0, 32'hB2B0_0003});
      end
      if (m_ack === 1'b1) begin
        nack++;
        if (nack == 1) t1 = i; else t2 = i;
        exp = 33'h0;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        n_checks++;
        if ({m_err, m_rdata} !== exp) begin
          n_fail++; $display("FAIL b2b_resp%0d: err/rdata=%b/%h want %b/%h", nack, m_err, m_rdata, exp[32], exp[31:0]);
        end
        if (nack == 2) m_req = 1'b0;
      end
    end
    s_ack = 4'b0000;
    n_checks++;
    if (nack !== 2 || t1 !== 2 || t2 - t1 !== 3) begin
      n_fail++; $display("FAIL b2b_timing: acks=%0d t1=%0d t2=%0d want 2/2/5", nack, t1, t2);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL sb_empty: %0d responses still expected, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_timeout();
    test_ack_at_timeout();
    test_spurious_ack();
    test_reset_mid_busy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
